fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side controller for the show-ahead fifo (push/pop/full/empty/data_out).
//  - On a start command, pops exactly `len` words from the fifo.
//  - Presents the words on a registered valid/ready stream; the final word is flagged `out_last`.
//  - Sits between the fifo's pop port and a downstream consumer. A 2-entry skid buffer decouples
//    out_ready from fifo_pop.
// PARAMETERS
//  WIDTH  8  data width; must equal the fifo WIDTH
//  LENW   8  width of the burst-length field and of the remaining-word counter
// PORTS
//  clk         in   1      clock; all state on posedge
//  rst         in   1      asynchronous, active-low reset (0 = reset)
//  start       in   1      burst request; sampled only in IDLE
//  len         in   LENW   burst length in words; sampled with start
//  busy        out  1      1 while state != IDLE
//  done        out  1      one-cycle pulse at burst completion
//  fifo_empty  in   1      fifo empty flag
//  fifo_data   in   WIDTH  fifo data_out (head entry, combinational, valid when !fifo_empty)
//  fifo_pop    out  1      fifo pop strobe
//  out_valid   out  1      stream valid
//  out_ready   in   1      stream ready
//  out_data    out  WIDTH  stream data (driven from the skid buffer head register)
//  out_last    out  1      qualifies out_data as the final word of the burst
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, remaining=0, buffer occupancy=0.
//   All outputs 0: busy, done, fifo_pop, out_valid, out_data, out_last.
//  States:
//   IDLE  -> DRAIN when start&&len!=0; remaining<=len.
//   IDLE  -> DONE when start&&len==0.
//   DRAIN -> DONE in the cycle after the handshake (out_valid&&out_ready) of the out_last word.
//   DONE  -> IDLE unconditionally after 1 cycle; done=1 exactly while in DONE.
//  start is ignored outside IDLE. len is captured once; later changes have no effect.
//  fifo_pop = (state==DRAIN) && !fifo_empty && remaining!=0 && occupancy<2.
//   - Combinational from current state and fifo_empty.
//   - Never asserted while fifo_empty=1.
//  Pop capture: when fifo_pop=1, fifo_data is written into the skid buffer in the same cycle
//   (show-ahead read, 0 wait states).
//   - remaining decrements by 1; width LENW, no wrap, since a pop requires remaining!=0.
//   - The entry's last tag is set when remaining==1 at the pop.
//  Skid buffer: 2 entries, FIFO order.
//   - out_valid = occupancy!=0.
//   - out_data and out_last come from the head entry.
//   - Handshake: when out_valid&&out_ready, the head retires.
//   - Push and retire in the same cycle: occupancy unchanged.
//  Latency: a word popped in cycle N is visible on out_data in cycle N+1.
//   Sustained 1 word/cycle with out_ready held 1.
//  AXI-style rules:
//   - out_valid, once asserted, stays 1 and out_data/out_last stay stable until the handshake.
//   - out_valid must not depend combinationally on out_ready.
//  Downstream stall: out_ready=0 -> buffer fills to 2, then fifo_pop=0; no data lost or duplicated.
//  Empty fifo mid-burst: DRAIN holds; popping resumes when fifo_empty drops. No timeout.
//  Reset mid-burst: everything returns to reset values next edge.
//   - Words already popped and buffered are discarded.
//   - The fifo is reset by the same rst at system level.
// CONFIGURATION
//  FIFO_RD_PARITY_EN
//   - Defined: adds output port out_par (1 bit) = ^out_data.
//     It is a stored bit per buffer entry, computed at pop time; reset 0.
//     It is held stable with out_data under the same valid/ready rules.
//   - Undefined: no out_par port, no parity storage; all other behaviour identical.
// TESTING
//  1 Reset: hold rst=0 with start=1,len=4 -> busy=0, out_valid=0, fifo_pop=0, done=0 throughout.
//  2 Full-rate burst:
//    - Stimulus: fifo holds 0x11,0x22,0x33; start,len=3; out_ready=1.
//    - fifo_pop high 3 consecutive cycles; out_data 0x11,0x22,0x33 on the next 3 cycles.
//    - out_last only with 0x33; done pulses 1 cycle after that handshake; then busy=0.
//  3 Backpressure:
//    - Stimulus: fifo holds 0xA0..0xA4; start,len=5; out_ready=0 for 6 cycles, then 1.
//    - Exactly 2 pops, then fifo_pop=0; out_data holds 0xA0 stable.
//    - After release, all 5 words arrive in order with no duplicates.
//  4 Underrun: start,len=4 with fifo holding 2 words; push 2 more 10 cycles later.
//    - busy stays 1, fifo_pop never asserted while fifo_empty=1.
//    - 4 words delivered, out_last on word 4, done once.
//  5 Zero length and ignored start: start,len=0 -> done next cycle, fifo_pop never asserted.
//    start,len=2 pulsed again mid-burst -> ignored; only the original len is popped.
//  6 Reset mid-burst and parity: assert rst=0 after 2 of 6 words delivered.
//    - All outputs 0 immediately; a new burst of len=1 afterwards works.
//    - With FIFO_RD_PARITY_EN: out_data=0x07 gives out_par=1; 0x03 gives out_par=0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops `len` words from a show-ahead fifo into a 2-entry skid buffer
// that feeds a valid/ready stream. Optional FIFO_RD_PARITY_EN adds a stored out_par bit.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LENW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LENW-1:0]           rem_q, rem_d;
  logic [1:0]                occ_q, occ_d, occ_after;
  logic [1:0][WIDTH-1:0]     buf_data_q, buf_data_d;
  logic [1:0]                buf_last_q, buf_last_d;
`ifdef FIFO_RD_PARITY_EN
  logic [1:0]                buf_par_q, buf_par_d;
`endif

  logic push;
  logic retire;
  logic push_last;

  // Entry 0 is always the head; occupancy never exceeds 2, so bit 1 set means full.
  assign out_valid = (occ_q != 2'd0);
  assign retire    = out_valid && out_ready;
  assign push      = (state_q == ST_DRAIN) && !fifo_empty && (rem_q != '0) && !occ_q[1];
  assign push_last = (rem_q == LENW'(1));
  assign fifo_pop  = push;

  assign out_data  = buf_data_q[0];
  assign out_last  = buf_last_q[0];
`ifdef FIFO_RD_PARITY_EN
  assign out_par   = buf_par_q[0];
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ST_DRAIN;
            rem_d   = len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (push) begin
          rem_d = rem_q - LENW'(1);
        end
        if (retire && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Retire shifts entry 1 forward first; a push then lands in the first free slot.
  always_comb begin
    occ_after  = occ_q - {1'b0, retire};
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
`ifdef FIFO_RD_PARITY_EN
    buf_par_d  = buf_par_q;
`endif
    if (retire) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
`ifdef FIFO_RD_PARITY_EN
      buf_par_d[0]  = buf_par_q[1];
`endif
    end
    if (push) begin
      if (occ_after == 2'd0) begin
        buf_data_d[0] = fifo_data;
        buf_last_d[0] = push_last;
`ifdef FIFO_RD_PARITY_EN
        buf_par_d[0]  = ^fifo_data;
`endif
      end else begin
        buf_data_d[1] = fifo_data;
        buf_last_d[1] = push_last;
`ifdef FIFO_RD_PARITY_EN
        buf_par_d[1]  = ^fifo_data;
`endif
      end
    end
    occ_d = occ_after + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      occ_q      <= 2'd0;
      buf_data_q <= '0;
      buf_last_q <= '0;
`ifdef FIFO_RD_PARITY_EN
      buf_par_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      occ_q      <= occ_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
`ifdef FIFO_RD_PARITY_EN
      buf_par_q  <= buf_par_d;
`endif
    end
  end

endmodule
